// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and one-cycle MTHI/MTLO.
// Operands are reduced to magnitudes at start; signs are reapplied in the FIX state.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             r_state;
  logic               r_div, r_sa, r_sb;
  logic [WIDTH-1:0]   r_m;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] r_acc;    // {hi accumulator/remainder, multiplier/quotient}
  logic [CW-1:0]      r_cnt;

  logic               w_sgn;
  logic [WIDTH-1:0]   w_absa, w_absb;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_prod;
  logic [WIDTH:0]     w_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_dif, w_quo, w_rem;
  logic               w_dz;

  assign w_sgn  = ~MDOp[0];
  assign w_absa = (w_sgn && SrcA[WIDTH-1]) ? -SrcA : SrcA;
  assign w_absb = (w_sgn && SrcB[WIDTH-1]) ? -SrcB : SrcB;

  // Shift-add: add multiplicand into the upper half when the current multiplier bit is set.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_m : {WIDTH{1'b0}})};
  assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

  // Restoring divide: shift in the next dividend bit, subtract if it fits.
  assign w_sh      = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge      = (w_sh >= {1'b0, r_m});
  assign w_dif     = w_sh[WIDTH-1:0] - r_m;
  assign w_div_nxt = {(w_ge ? w_dif : w_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  // With a zero divisor the remainder path reproduces |dividend|, so the
  // remainder sign fix alone restores the captured SrcA.
  assign w_dz   = (r_m == '0);
  assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_quo  = w_dz ? '1 : ((r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_rem  = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_div   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_m     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      Done <= 1'b0;
      case (r_state)
        IDLE: if (Start) begin
          if (!MDOp[2]) begin
            r_div   <= MDOp[1];
            r_sa    <= w_sgn & SrcA[WIDTH-1];
            r_sb    <= w_sgn & SrcB[WIDTH-1];
            r_m     <= MDOp[1] ? w_absb : w_absa;
            r_acc   <= {{WIDTH{1'b0}}, (MDOp[1] ? w_absa : w_absb)};
            r_cnt   <= '0;
            Busy    <= 1'b1;
            r_state <= RUN;
          end else if (MDOp == 3'b100) begin
            HI <= SrcA;
          end else if (MDOp == 3'b101) begin
            LO <= SrcA;
          end
        end
        RUN: begin
          r_acc <= r_div ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) r_state <= FIX;
        end
        FIX: begin
          if (r_div) begin
            HI <= w_rem;
            LO <= w_quo;
          end else begin
            HI <= w_prod[2*WIDTH-1:WIDTH];
            LO <= w_prod[WIDTH-1:0];
          end
          Busy    <= 1'b0;
          Done    <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed-vector bench: stimulus pushes expected {HI,LO} into a queue,
// a negedge monitor pops and compares on every Done pulse.
module tb_mips_muldiv_unit;
  logic        clk, rst_n, Start;
  logic [2:0]  MDOp;
  logic [31:0] SrcA, SrcB, HI, LO;
  logic        Busy, Done;

  int tests = 0;
  int fails = 0;
  logic [63:0] q[$];

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .MDOp(MDOp), .SrcA(SrcA), .SrcB(SrcB),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && Done) begin
      logic [63:0] e;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: HI=%h LO=%h", HI, LO);
      end else begin
        e = q.pop_front();
        if ({HI, LO} !== e || Busy !== 1'b0) begin
          fails++;
          $display("FAIL result: got HI=%h LO=%h Busy=%b, want HI=%h LO=%h Busy=0",
                   HI, LO, Busy, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo);
    Start = 1'b1; MDOp = op; SrcA = a; SrcB = b;
    q.push_back({ehi, elo});
    @(negedge clk);
    Start = 1'b0; MDOp = 3'b111; SrcA = 32'hA5A5_A5A5; SrcB = 32'h5A5A_5A5A;
  endtask

  task automatic wait_done(output int nb);
    nb = 0;
    for (int i = 0; i < 60 && !Done; i++) begin
      if (Busy) nb++;
      @(negedge clk);
    end
    if (!Done) begin
      tests++; fails++;
      $display("FAIL timeout: Done never seen, Busy=%b", Busy);
      q.delete();
    end
  endtask

  task automatic op_full(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo);
    int nb;
    issue(op, a, b, ehi, elo);
    wait_done(nb);
    check("busy_cycles", 32'(nb), 32'd33);
  endtask

  initial begin
    int nb;
    rst_n = 1'b0; Start = 1'b0; MDOp = 3'b111; SrcA = '0; SrcB = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // multiply
    op_full(3'b000, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
    op_full(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    op_full(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    op_full(3'b000, 32'h8000_0000, 32'd2,        32'hFFFF_FFFF, 32'h0000_0000);
    // divide
    op_full(3'b010, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    op_full(3'b011, 32'd100,       32'd7,        32'd2,         32'd14);
    op_full(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    op_full(3'b010, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
    op_full(3'b011, 32'h0000_0064, 32'd0,        32'h0000_0064, 32'hFFFF_FFFF);
    op_full(3'b010, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // MTHI attempt during a multiply is ignored
    issue(3'b000, 32'd5, 32'd6, 32'd0, 32'd30);
    repeat (9) @(negedge clk);
    Start = 1'b1; MDOp = 3'b100; SrcA = 32'h0000_DEAD;
    @(negedge clk);
    Start = 1'b0; MDOp = 3'b111;
    check("hold_hi_busy", HI, 32'hFFFF_FFF9);
    wait_done(nb);
    @(negedge clk);

    // MTLO / MTHI / reserved op while idle
    Start = 1'b1; MDOp = 3'b101; SrcA = 32'h0000_1234;
    @(negedge clk);
    Start = 1'b0; MDOp = 3'b111;
    check("mtlo_lo", LO, 32'h0000_1234);
    check("mtlo_done", {31'd0, Done}, 32'd0);
    check("mtlo_busy", {31'd0, Busy}, 32'd0);
    Start = 1'b1; MDOp = 3'b100; SrcA = 32'hCAFE_0001;
    @(negedge clk);
    check("mthi_hi", HI, 32'hCAFE_0001);
    MDOp = 3'b110; SrcA = 32'h1111_1111;
    @(negedge clk);
    Start = 1'b0; MDOp = 3'b111;
    check("nop_hi", HI, 32'hCAFE_0001);
    check("nop_lo", LO, 32'h0000_1234);
    check("nop_busy", {31'd0, Busy}, 32'd0);

    // reset in the middle of a divide
    Start = 1'b1; MDOp = 3'b011; SrcA = 32'd1000; SrcB = 32'd3;
    @(negedge clk);
    Start = 1'b0; MDOp = 3'b111;
    repeat (14) @(negedge clk);
    check("busy_before_abort", {31'd0, Busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_done", {31'd0, Done}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op_full(3'b001, 32'd3, 32'd4, 32'd0, 32'd12);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
